scr1_trace_stream: RTL and testbench

Synthesizable counterpart to the simulation trace logger: captures retire-time PC updates and MPRF writes from the pipeline into an on-chip record FIFO. It streams each record out as 32-bit words over a valid/ready port, for a debug or trace-sink consumer. It sits beside the pipeline and taps the same EXU/MPRF signals the logger uses, but must synthesize.

---
 rtl/scr1_trace_stream_pkg.sv | 30 +++
 rtl/scr1_trace_stream_if.sv | 9 +
 rtl/scr1_trace_fifo.sv | 37 +++
 rtl/scr1_trace_stream.sv | 103 ++++++++++
 tb/tb_scr1_trace_stream.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_trace_stream_pkg.sv
// scr1_trace_pkg: trace record layout, header bit positions and serializer states
package scr1_trace_pkg;
  localparam int HDR_UP = 31;
  localparam int HDR_LOST = 30;
  localparam int HDR_ADDR_LSB = 16;
  localparam int HDR_DELAY_LSB = 0;
  typedef struct packed {
    logic        up;
    logic        lost;
    logic [4:0]  addr;
    logic [15:0] delay;
    logic [31:0] pc;
    logic [31:0] data;
  } type_scr1_trace_rec_s;
  typedef enum logic [1:0] {
    TRACE_IDLE,
    TRACE_HDR,
    TRACE_PC,
    TRACE_DATA
  } type_scr1_trace_fsm_e;
  function automatic logic [31:0] trace_hdr(input type_scr1_trace_rec_s r);
    logic [31:0] h;
    h = '0;
    h[HDR_UP] = r.up;
    h[HDR_LOST] = r.lost;
    h[HDR_ADDR_LSB +: 5] = r.addr;
    h[HDR_DELAY_LSB +: 16] = r.delay;
    return h;
  endfunction
endpackage

// File: rtl/scr1_trace_stream_if.sv
// scr1_trace_stream_if: valid/ready word stream carrying serialized trace records
interface scr1_trace_stream_if;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_ready;
  modport master(output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave(input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/scr1_trace_fifo.sv
// scr1_trace_fifo: synchronous FIFO with head and head+1 peek for back-to-back draining
module scr1_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [WIDTH-1:0]         rnext,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [AW-1:0] nidx;
  assign nidx = rptr[AW-1:0] + AW'(1);
  assign rdata = mem[rptr[AW-1:0]];
  assign rnext = mem[nidx];
  assign level = wptr - rptr;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = wptr == rptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/scr1_trace_stream.sv
// scr1_trace_stream: captures retire PC updates and MPRF writes into a record FIFO
// and streams each record as 2 or 3 words over a valid/ready port.
module scr1_trace_stream
  import scr1_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  logic                   update_pc_en,
  input  logic [31:0]            update_pc,
  input  logic                   mprf_wr_en,
  input  logic [4:0]             mprf_wr_addr,
  input  logic [31:0]            mprf_wr_data,
  scr1_trace_stream_if.master    rd,
  output logic                   ovf,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;
  type_scr1_trace_fsm_e state, state_n;
  type_scr1_trace_rec_s rec, head, nxt;
  logic [31:0] last_pc, data_q, data_n;
  logic [15:0] delay;
  logic        lost, last_q, last_n, capture, push, pop, drop, full, empty, more;
  assign capture = trace_en & (update_pc_en | mprf_wr_en);
  assign pop = rd.rd_valid & rd.rd_ready & rd.rd_last;
  assign push = capture & (~full | pop);
  assign drop = capture & full & ~pop;
  assign more = level > LW'(1);
  assign rd.rd_valid = state != TRACE_IDLE;
  assign rd.rd_data = data_q;
  assign rd.rd_last = last_q;
  always_comb begin
    rec.up = mprf_wr_en & (mprf_wr_addr != 5'd0);
    rec.lost = lost;
    rec.addr = mprf_wr_addr;
    rec.delay = delay;
    rec.pc = update_pc_en ? update_pc : last_pc;
    rec.data = mprf_wr_data;
  end
  scr1_trace_fifo #(.WIDTH($bits(type_scr1_trace_rec_s)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .wdata(rec), .pop(pop),
    .rdata(head), .rnext(nxt), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_pc <= '0;
      delay <= '0;
      lost <= 1'b0;
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (update_pc_en) last_pc <= update_pc;
      delay <= !trace_en ? 16'd0 : capture ? 16'd1 : (delay == 16'hffff) ? delay : delay + 16'd1;
      lost <= drop ? 1'b1 : push ? 1'b0 : lost;
      if (drop) ovf <= 1'b1;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
  // the next header comes from head+1 so a new record starts on the pop edge
  always_comb begin
    state_n = state;
    data_n = data_q;
    last_n = last_q;
    case (state)
      TRACE_IDLE:
        if (!empty) begin
          state_n = TRACE_HDR;
          data_n = trace_hdr(head);
          last_n = 1'b0;
        end
      TRACE_HDR:
        if (rd.rd_ready) begin
          state_n = TRACE_PC;
          data_n = head.pc;
          last_n = ~head.up;
        end
      default:
        if (rd.rd_ready) begin
          if (state == TRACE_PC && head.up) begin
            state_n = TRACE_DATA;
            data_n = head.data;
            last_n = 1'b1;
          end else begin
            state_n = more ? TRACE_HDR : TRACE_IDLE;
            data_n = more ? trace_hdr(nxt) : 32'd0;
            last_n = 1'b0;
          end
        end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= TRACE_IDLE;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      data_q <= data_n;
      last_q <= last_n;
    end
endmodule

// File: tb/tb_scr1_trace_stream.sv
// tb_scr1_trace_stream: directed steps with a reference scoreboard of expected stream words
module tb_scr1_trace_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_en = 1'b0;
  logic        upe = 1'b0;
  logic [31:0] upc = '0;
  logic        mwe = 1'b0;
  logic [4:0]  mwa = '0;
  logic [31:0] mwd = '0;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic [3:0]  level;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] d; logic l;} word_t;
  word_t q[$];
  int m_level;
  int m_drops;
  logic [15:0] m_delay;
  logic [31:0] m_pc;
  logic m_lost, m_ovf, stall_prev, prev_l;
  logic [31:0] prev_d;
  scr1_trace_stream_if sif();
  scr1_trace_stream #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .update_pc_en(upe), .update_pc(upc),
    .mprf_wr_en(mwe), .mprf_wr_addr(mwa), .mprf_wr_data(mwd), .rd(sif),
    .ovf(ovf), .drop_cnt(drop_cnt), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 50 && sif.rd_valid !== 1'b1; i++) tick();
    chk("wait_valid", sif.rd_valid, 1);
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 100 && (level !== 4'd0 || sif.rd_valid !== 1'b0); i++) tick();
    chk("drain_level", level, 0);
    chk("drain_queue", q.size(), 0);
  endtask
  task automatic monitor();
    logic pop_evt, cap, up;
    logic [31:0] pc;
    word_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_level = 0; m_drops = 0; m_delay = '0; m_pc = '0;
        m_lost = 0; m_ovf = 0; stall_prev = 0;
      end else begin
        chk("level", level, m_level);
        chk("ovf", ovf, m_ovf);
        chk("drop_cnt", drop_cnt, m_drops);
        if (stall_prev) begin
          chk("hold_valid", sif.rd_valid, 1);
          chk("hold_data", sif.rd_data, prev_d);
          chk("hold_last", sif.rd_last, prev_l);
        end
        pop_evt = 0;
        if (sif.rd_valid && sif.rd_ready) begin
          checks++;
          assert (q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_word got=%h exp=none", sif.rd_data);
          end
          if (q.size() > 0) begin
            w = q.pop_front();
            chk("word", sif.rd_data, w.d);
            chk("last", sif.rd_last, w.l);
            pop_evt = w.l;
          end
        end
        stall_prev = sif.rd_valid & ~sif.rd_ready;
        prev_d = sif.rd_data;
        prev_l = sif.rd_last;
        cap = trace_en & (upe | mwe);
        if (cap) begin
          if (m_level < 8 || pop_evt) begin
            up = mwe && mwa != 0;
            pc = upe ? upc : m_pc;
            q.push_back('{{up, m_lost, 9'd0, mwa, m_delay}, 1'b0});
            q.push_back('{pc, !up});
            if (up) q.push_back('{mwd, 1'b1});
            m_level++;
            m_lost = 0;
          end else begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
            m_lost = 1;
          end
        end
        if (pop_evt) m_level--;
        if (upe) m_pc = upc;
        m_delay = !trace_en ? 16'd0 : cap ? 16'd1 : (m_delay == 16'hffff) ? m_delay : m_delay + 16'd1;
      end
    end
  endtask
  initial begin
    sif.rd_ready = 1'b1;
    fork monitor(); join_none
    tick(); tick(); tick();
    chk("rst_valid", sif.rd_valid, 0);
    chk("rst_data", sif.rd_data, 0);
    chk("rst_last", sif.rd_last, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_level", level, 0);
    rst = 0;
    trace_en = 1;
    tick();
    upe = 1; upc = 32'h200; mwe = 1; mwa = 5; mwd = 32'hDEADBEEF;
    tick();
    upe = 0; mwe = 0; mwa = 0;
    chk("n1_level", level, 1);
    chk("n1_valid", sif.rd_valid, 0);
    tick();
    chk("n2_valid", sif.rd_valid, 1);
    chk("n2_hdr", sif.rd_data, 32'h80050001);
    chk("n2_last", sif.rd_last, 0);
    tick();
    chk("n3_pc", sif.rd_data, 32'h200);
    chk("n3_last", sif.rd_last, 0);
    upe = 1; upc = 32'h204;
    tick();
    upe = 0;
    chk("n4_data", sif.rd_data, 32'hDEADBEEF);
    chk("n4_last", sif.rd_last, 1);
    tick();
    chk("pconly_hdr", sif.rd_data, 32'h00000003);
    chk("pconly_valid", sif.rd_valid, 1);
    tick();
    chk("pconly_pc", sif.rd_data, 32'h204);
    chk("pconly_last", sif.rd_last, 1);
    tick();
    chk("idle_valid", sif.rd_valid, 0);
    sif.rd_ready = 0;
    mwe = 1; mwa = 3; mwd = 32'h12345678;
    tick();
    mwe = 0; mwa = 0;
    wait_valid();
    for (int i = 0; i < 10; i++) tick();
    chk("bp_valid", sif.rd_valid, 1);
    chk("bp_hdr_up", sif.rd_data[31], 1);
    sif.rd_ready = 1;
    tick();
    chk("bp_pc", sif.rd_data, 32'h204);
    tick();
    chk("bp_data", sif.rd_data, 32'h12345678);
    chk("bp_last", sif.rd_last, 1);
    tick();
    sif.rd_ready = 0;
    for (int i = 0; i < 10; i++) begin
      upe = 1; upc = 32'h1000 + 32'(4 * i);
      tick();
    end
    upe = 0;
    tick();
    chk("ovf_level", level, 8);
    chk("ovf_flag", ovf, 1);
    chk("ovf_drops", drop_cnt, 2);
    sif.rd_ready = 1;
    wait_drain();
    upe = 1; upc = 32'h2000;
    tick();
    upe = 0;
    wait_valid();
    chk("lost_bit", sif.rd_data[30], 1);
    wait_drain();
    sif.rd_ready = 0;
    for (int i = 0; i < 8; i++) begin
      upe = 1; upc = 32'h3000 + 32'(4 * i);
      tick();
    end
    upe = 0;
    wait_valid();
    chk("full_level", level, 8);
    sif.rd_ready = 1;
    tick();
    upe = 1; upc = 32'h3100;
    tick();
    upe = 0;
    chk("fullpop_level", level, 8);
    chk("fullpop_drops", drop_cnt, 2);
    wait_drain();
    upe = 1; upc = 32'h300;
    tick();
    upe = 0;
    wait_valid();
    tick();
    chk("mid_pc_state", sif.rd_data, 32'h300);
    rst = 1;
    #1;
    chk("mid_rst_valid", sif.rd_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", ovf, 0);
    tick();
    rst = 0;
    tick();
    upe = 1; upc = 32'h400;
    tick();
    upe = 0;
    tick();
    chk("post_rst_hdr", sif.rd_data, 32'h00000001);
    chk("post_rst_valid", sif.rd_valid, 1);
    tick();
    chk("post_rst_pc", sif.rd_data, 32'h400);
    chk("post_rst_last", sif.rd_last, 1);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
